// File: rtl/mips_reg_write_arbiter.sv
// Register-file write-port arbiter for the MIPS pipeline: grants one of the ALU (A) or
// load (B) writeback requesters per cycle, registers the write, and tracks pending writes.
module mips_reg_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [ADDR_W-1:0]        a_reg,
    input  logic [DATA_W-1:0]        a_data,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [ADDR_W-1:0]        b_reg,
    input  logic [DATA_W-1:0]        b_data,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_reg,
    input  logic [ADDR_W-1:0]        rs,
    input  logic [ADDR_W-1:0]        rt,
    output logic                     hazard_rs,
    output logic                     hazard_rt,
    output logic                     signal_reg_write,
    output logic [ADDR_W-1:0]        write_reg,
    output logic [DATA_W-1:0]        write_data,
    output logic [(1<<ADDR_W)-1:0]   busy_mask
);

    localparam int NREG  = 1 << ADDR_W;
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] wr_q, wr_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [NREG-1:0]   busy_q, busy_d;

    logic              force_a_s;
    logic              grant_a_s;
    logic              grant_b_s;
    logic [ADDR_W-1:0] win_reg_s;
    logic [DATA_W-1:0] win_data_s;

    // Grant selection: B wins unless A has waited STARVE_LIMIT cycles; nothing granted in reset.
    always_comb begin
        force_a_s  = a_valid && (starve_q == LIMIT_C);
        grant_b_s  = !rst && b_valid && !force_a_s;
        grant_a_s  = !rst && a_valid && (force_a_s || !b_valid);
        win_reg_s  = grant_b_s ? b_reg  : a_reg;
        win_data_s = grant_b_s ? b_data : a_data;
    end

    assign a_ready = grant_a_s;
    assign b_ready = grant_b_s;

    // Next-state for starvation counter, write register and scoreboard.
    always_comb begin
        starve_d = starve_q;
        we_d     = 1'b0;
        wr_d     = wr_q;
        wd_d     = wd_q;
        busy_d   = busy_q;

        if (!a_valid || grant_a_s) begin
            starve_d = '0;
        end else if (starve_q != LIMIT_C) begin
            starve_d = starve_q + CNT_W'(1);
        end else begin
            starve_d = starve_q;
        end

        // Register 0 is accepted and latched but never written to the register file.
        if (grant_a_s || grant_b_s) begin
            we_d              = (win_reg_s != '0);
            wr_d              = win_reg_s;
            wd_d              = win_data_s;
            busy_d[win_reg_s] = 1'b0;
        end else begin
            we_d = 1'b0;
        end

        // A new reservation overrides a clear of the same register on the same edge.
        if (issue_valid && (issue_reg != '0)) begin
            busy_d[issue_reg] = 1'b1;
        end else begin
            busy_d[0] = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
            we_q     <= 1'b0;
            wr_q     <= '0;
            wd_q     <= '0;
            busy_q   <= '0;
        end else begin
            starve_q <= starve_d;
            we_q     <= we_d;
            wr_q     <= wr_d;
            wd_q     <= wd_d;
            busy_q   <= busy_d;
        end
    end

    // Hazards also cover the cycle between the scoreboard clear and the register-file commit.
    always_comb begin
        hazard_rs = (rs != '0) && (busy_q[rs] || (we_q && (wr_q == rs)));
        hazard_rt = (rt != '0) && (busy_q[rt] || (we_q && (wr_q == rt)));
    end

    assign signal_reg_write = we_q;
    assign write_reg        = wr_q;
    assign write_data       = wd_q;
    assign busy_mask        = busy_q;

endmodule

// File: tb/tb_mips_reg_write_arbiter.sv
// Self-checking bench for mips_reg_write_arbiter: directed scenarios plus a randomized
// run compared against a rule-level reference model.
module tb_mips_reg_write_arbiter;

    localparam int LIM = 3;

    logic        clk, rst;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [4:0]  a_reg, b_reg, issue_reg, rs, rt, write_reg;
    logic [31:0] a_data, b_data, write_data, busy_mask;
    logic        issue_valid, hazard_rs, hazard_rt, signal_reg_write;

    int errors = 0;
    int checks = 0;

    mips_reg_write_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .issue_valid(issue_valid), .issue_reg(issue_reg), .rs(rs), .rt(rt),
        .hazard_rs(hazard_rs), .hazard_rt(hazard_rt),
        .signal_reg_write(signal_reg_write), .write_reg(write_reg),
        .write_data(write_data), .busy_mask(busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; a_reg = 5'd0; a_data = 32'd0;
        b_valid = 1'b0; b_reg = 5'd0; b_data = 32'd0;
        issue_valid = 1'b0; issue_reg = 5'd0; rs = 5'd0; rt = 5'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        a_valid = 1'b1; a_reg = 5'd3; a_data = 32'hAA;
        issue_valid = 1'b1; issue_reg = 5'd6;
        tick();
        issue_valid = 1'b0; a_reg = 5'd4;
        checks++; if (signal_reg_write !== 1'b1) begin errors++; $display("FAIL reset_pre_we got=%0h exp=1", signal_reg_write); end
        #2 rst = 1'b1;
        #1;
        checks++; if (signal_reg_write !== 1'b0) begin errors++; $display("FAIL reset_we got=%0h exp=0", signal_reg_write); end
        checks++; if (write_reg !== 5'd0) begin errors++; $display("FAIL reset_wr got=%0h exp=0", write_reg); end
        checks++; if (write_data !== 32'd0) begin errors++; $display("FAIL reset_wd got=%0h exp=0", write_data); end
        checks++; if (busy_mask !== 32'd0) begin errors++; $display("FAIL reset_busy got=%0h exp=0", busy_mask); end
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready got=%0h exp=0", a_ready); end
        a_valid = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (signal_reg_write !== 1'b0) begin errors++; $display("FAIL reset_idle_we[%0d] got=%0h exp=0", i, signal_reg_write); end
        end
    endtask

    task automatic test_single_write();
        do_reset();
        issue_valid = 1'b1; issue_reg = 5'd5;
        tick();
        issue_valid = 1'b0;
        checks++; if (busy_mask[5] !== 1'b1) begin errors++; $display("FAIL single_busy_set got=%0h exp=1", busy_mask[5]); end
        a_valid = 1'b1; a_reg = 5'd5; a_data = 32'hDEADBEEF; rs = 5'd5;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL single_a_ready got=%0h exp=1", a_ready); end
        checks++; if (hazard_rs !== 1'b1) begin errors++; $display("FAIL single_hz_busy got=%0h exp=1", hazard_rs); end
        tick();
        a_valid = 1'b0;
        #1;
        checks++; if (signal_reg_write !== 1'b1) begin errors++; $display("FAIL single_we got=%0h exp=1", signal_reg_write); end
        checks++; if (write_reg !== 5'd5) begin errors++; $display("FAIL single_wr got=%0h exp=5", write_reg); end
        checks++; if (write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wd got=%0h exp=deadbeef", write_data); end
        checks++; if (busy_mask[5] !== 1'b0) begin errors++; $display("FAIL single_busy_clr got=%0h exp=0", busy_mask[5]); end
        checks++; if (hazard_rs !== 1'b1) begin errors++; $display("FAIL single_hz_gap got=%0h exp=1", hazard_rs); end
        tick();
        #1;
        checks++; if (signal_reg_write !== 1'b0) begin errors++; $display("FAIL single_we_after got=%0h exp=0", signal_reg_write); end
        checks++; if (hazard_rs !== 1'b0) begin errors++; $display("FAIL single_hz_after got=%0h exp=0", hazard_rs); end
        rs = 5'd0;
    endtask

    task automatic test_contention();
        logic [7:0] pat;
        pat = 8'b1000_1000;  // bit i set: cycle i goes to A (B,B,B,A,B,B,B,A)
        do_reset();
        a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h3;
        b_valid = 1'b1; b_reg = 5'd4; b_data = 32'h4;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (a_ready !== pat[i] || b_ready !== !pat[i]) begin
                errors++; $display("FAIL contention_grant[%0d] got a=%0h b=%0h exp a=%0h", i, a_ready, b_ready, pat[i]);
            end
            tick();
            checks++; if (write_reg !== (pat[i] ? 5'd3 : 5'd4)) begin
                errors++; $display("FAIL contention_wr[%0d] got=%0h exp=%0h", i, write_reg, pat[i] ? 5'd3 : 5'd4);
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic test_reg0();
        do_reset();
        b_valid = 1'b1; b_reg = 5'd0; b_data = 32'h1234;
        #1;
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL reg0_b_ready got=%0h exp=1", b_ready); end
        tick();
        b_valid = 1'b0;
        checks++; if (signal_reg_write !== 1'b0) begin errors++; $display("FAIL reg0_we got=%0h exp=0", signal_reg_write); end
        issue_valid = 1'b1; issue_reg = 5'd0; rs = 5'd0;
        tick();
        issue_valid = 1'b0;
        checks++; if (busy_mask !== 32'd0) begin errors++; $display("FAIL reg0_busy got=%0h exp=0", busy_mask); end
        checks++; if (hazard_rs !== 1'b0) begin errors++; $display("FAIL reg0_hz got=%0h exp=0", hazard_rs); end
    endtask

    task automatic test_set_clear();
        do_reset();
        issue_valid = 1'b1; issue_reg = 5'd7;
        tick();
        a_valid = 1'b1; a_reg = 5'd7; a_data = 32'h77;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL setclr_a_ready got=%0h exp=1", a_ready); end
        tick();
        issue_valid = 1'b0; a_valid = 1'b0;
        checks++; if (busy_mask[7] !== 1'b1) begin errors++; $display("FAIL setclr_busy got=%0h exp=1", busy_mask[7]); end
        checks++; if (signal_reg_write !== 1'b1 || write_reg !== 5'd7) begin
            errors++; $display("FAIL setclr_write got we=%0h wr=%0h exp we=1 wr=7", signal_reg_write, write_reg);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        a_valid = 1'b1; a_reg = 5'd9; a_data = 32'h1;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL order_a_ready got=%0h exp=1", a_ready); end
        tick();
        a_valid = 1'b0; b_valid = 1'b1; b_reg = 5'd9; b_data = 32'h2;
        #1;
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL order_b_ready got=%0h exp=1", b_ready); end
        checks++; if (signal_reg_write !== 1'b1 || write_data !== 32'h1) begin
            errors++; $display("FAIL order_first got we=%0h wd=%0h exp we=1 wd=1", signal_reg_write, write_data);
        end
        tick();
        b_valid = 1'b0;
        checks++; if (signal_reg_write !== 1'b1 || write_reg !== 5'd9 || write_data !== 32'h2) begin
            errors++; $display("FAIL order_second got we=%0h wr=%0h wd=%0h exp we=1 wr=9 wd=2", signal_reg_write, write_reg, write_data);
        end
        tick();
        checks++; if (signal_reg_write !== 1'b0 || write_data !== 32'h2) begin
            errors++; $display("FAIL order_idle got we=%0h wd=%0h exp we=0 wd=2", signal_reg_write, write_data);
        end
    endtask

    task automatic test_random();
        bit          m_busy[32];
        int          m_starve;
        bit          m_we;
        logic [4:0]  m_wr;
        logic [31:0] m_wd, m_mask;
        bit          a_pend, b_pend, fa, ga, gb, hrs, hrt;
        do_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_starve = 0; m_we = 1'b0; m_wr = 5'd0; m_wd = 32'd0;
        a_pend = 1'b0; b_pend = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!a_pend) begin
                a_valid = ($urandom_range(0, 9) < 6); a_reg = 5'($urandom_range(0, 7)); a_data = $urandom;
            end
            if (!b_pend) begin
                b_valid = ($urandom_range(0, 9) < 5); b_reg = 5'($urandom_range(0, 7)); b_data = $urandom;
            end
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_reg = 5'($urandom_range(0, 7));
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(0, 7));
            #1;
            fa = a_valid && (m_starve >= LIM);
            gb = b_valid && !fa;
            ga = a_valid && !gb;
            for (int i = 0; i < 32; i++) m_mask[i] = m_busy[i];
            hrs = (rs != 5'd0) && (m_busy[rs] || (m_we && m_wr == rs));
            hrt = (rt != 5'd0) && (m_busy[rt] || (m_we && m_wr == rt));
            checks++; if (a_ready !== ga || b_ready !== gb) begin
                errors++; $display("FAIL rand_grant[%0d] got a=%0h b=%0h exp a=%0h b=%0h", c, a_ready, b_ready, ga, gb);
            end
            checks++; if (hazard_rs !== hrs || hazard_rt !== hrt) begin
                errors++; $display("FAIL rand_hazard[%0d] got rs=%0h rt=%0h exp rs=%0h rt=%0h", c, hazard_rs, hazard_rt, hrs, hrt);
            end
            checks++; if (signal_reg_write !== m_we || write_reg !== m_wr || write_data !== m_wd) begin
                errors++; $display("FAIL rand_write[%0d] got we=%0h wr=%0h wd=%0h exp we=%0h wr=%0h wd=%0h",
                                   c, signal_reg_write, write_reg, write_data, m_we, m_wr, m_wd);
            end
            checks++; if (busy_mask !== m_mask) begin
                errors++; $display("FAIL rand_busy[%0d] got=%0h exp=%0h", c, busy_mask, m_mask);
            end
            if (ga || gb) begin
                m_wr = gb ? b_reg : a_reg;
                m_wd = gb ? b_data : a_data;
                m_we = (m_wr != 5'd0);
                m_busy[m_wr] = 1'b0;
            end else begin
                m_we = 1'b0;
            end
            if (issue_valid && issue_reg != 5'd0) m_busy[issue_reg] = 1'b1;
            if (!a_valid || ga) m_starve = 0;
            else if (m_starve < LIM) m_starve = m_starve + 1;
            a_pend = a_valid && !ga;
            b_pend = b_valid && !gb;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_write();
        test_contention();
        test_reg0();
        test_set_clear();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
